bus_arbiter_rr4: RTL and testbench
==================================

// Module: bus_arbiter_rr4
// PURPOSE
//   Round-robin arbiter/sequencer for a 4-source shared tristate bus. Each of 4
//   requesters drives its operand onto the bus only while granted; the block
//   owns the select code and the per-source drive enables. It also provides a
//   registered bus sample to the downstream stage. One dead (turnaround) cycle
//   separates successive owners so that no two drivers ever overlap.
// PARAMETERS
//   WIDTH     8   data width of each source and of the bus sample
//   MAX_HOLD  4   max consecutive grant cycles while others wait; 0 = no preemption (range 0..255)
// PORTS
//   clk      in   1      single clock, all state on rising edge
//   rst      in   1      asynchronous, active-high reset
//   req      in   4      per-requester bus request, level-sensitive
//   d0..d3   in   WIDTH  requester data, one port per source
//   gnt      out  4      one-hot grant = tristate drive enable for that source
//   sel      out  2      encoded owner index (00..11), valid while bus_en=1
//   bus_en   out  1      1 = some source owns the bus this cycle
//   y        out  WIDTH  registered bus sample
//   y_valid  out  1      y holds data sampled from a granted source
// BEHAVIOUR
//   Reset (async, immediate, no clock needed): state=IDLE, gnt=0, sel=0,
//     bus_en=0, y=0, y_valid=0, priority ptr=0, hold_cnt=0.
//   All outputs are registered. The bus net is resolved internally: the source
//     selected by sel drives it, otherwise it is Z. y never samples Z.
//   Arbitration: winner = first set bit of req scanning ptr, ptr+1, .. mod 4.
//   States:
//     IDLE  : req==0 -> stay. Otherwise, at the next edge: gnt=onehot(winner),
//             sel=winner, bus_en=1, hold_cnt=0, -> GRANT.
//             Latency from req sampled high to gnt high is 1 cycle.
//     GRANT : hold_cnt += 1, saturating at 255. Release condition is either:
//             (a) req[sel]==0; or
//             (b) MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~gnt)!=0.
//             On release: gnt=0, bus_en=0, ptr=(sel+1) mod 4, -> TURN.
//             If (b)'s count is reached with no other requester, keep holding.
//     TURN  : exactly 1 cycle with all gnt=0. Arbitrates like IDLE: any req
//             -> GRANT to the winner at the next edge, else -> IDLE.
//             A preempted owner still requesting competes with the advanced
//             ptr, so it has lowest priority.
//   Data: each edge, if bus_en==1 then y<=d[sel]. y_valid<=bus_en.
//     When bus_en==0, y holds its last value and y_valid is 0.
//     Sample latency is 1 cycle after the owning cycle.
//   sel holds the last owner while bus_en==0. Consumers must qualify with bus_en.
//   Invariant: popcount(gnt)<=1 every cycle. gnt!=0 iff bus_en. Never two
//     consecutive cycles with different nonzero gnt.
//   Simultaneous requests resolve only by ptr. A req rising during TURN is
//     eligible in that same TURN cycle.
//   Unused state encoding -> IDLE with outputs cleared.
//   rst asserted mid-GRANT: gnt/bus_en drop immediately.
// TESTING
//   1 rst=1 with req=4'b1111 -> gnt=0, bus_en=0, y_valid=0. After rst drops,
//     first edge -> gnt=0001, sel=00.
//   2 req=1111 held, MAX_HOLD=4 -> owners 0,1,2,3,0. Each has 4 gnt cycles,
//     separated by 1 cycle of gnt=0.
//   3 req=0100 only for 10 cycles, MAX_HOLD=4 -> gnt=0100 continuously,
//     no turnaround inserted.
//   4 owner 2, d2=8'hA5 -> y=8'hA5, y_valid=1 on the edge after bus_en=1.
//     After release, y stays A5 and y_valid=0.
//   5 owner 1, req drops to 1000 -> next edge gnt=0 (TURN), then gnt=1000.
//     ptr=2, so requester 3 wins over a re-raised req[0].
//   6 rst pulsed mid-GRANT between edges -> gnt/bus_en/y_valid=0 immediately.
//     Arbitration restarts with ptr=0.

Source files
------------

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter for a 4-source shared bus. It inserts one turnaround cycle
// between owners, can preempt a long holder, and registers a sample of the bus.
module bus_arbiter_rr4 #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             bus_en,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             bus_en_q, bus_en_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;

  logic             any_req;
  logic [1:0]       winner;
  logic             hold_limit;
  logic             release_now;
  logic [WIDTH-1:0] bus_data;

  // The bus is modelled as the resolved value of the selected driver; sampling
  // is gated by bus_en so a floating bus is never captured.
  always_comb begin
    case (sel_q)
      2'd0:    bus_data = d0;
      2'd1:    bus_data = d1;
      2'd2:    bus_data = d2;
      default: bus_data = d3;
    endcase
  end

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    any_req = |req;
    winner  = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) winner = ptr_q + 2'(i);
    end
  end

  always_comb begin
    hold_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) &&
                  ((req & ~gnt_q) != 4'b0000);
    release_now = !req[sel_q] || hold_limit;
  end

  // NOTE: every register, outputs included, is cleared by the async reset, so
  // gnt and bus_en fall the moment rst rises with no clock required.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      bus_en_q   <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      bus_en_q   <= bus_en_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (release_now) state_d = TURN;
      TURN:    state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so that no path through the case infers a latch.
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    bus_en_d   = bus_en_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    y_d        = bus_en_q ? bus_data : y_q;
    y_valid_d  = bus_en_q;
    case (state_q)
      IDLE, TURN: begin
        gnt_d      = '0;
        bus_en_d   = 1'b0;
        hold_cnt_d = '0;
        if (any_req) begin
          gnt_d    = 4'b0001 << winner;
          sel_d    = winner;
          bus_en_d = 1'b1;
        end
      end
      GRANT: begin
        if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
        // Advancing ptr past the owner gives a preempted owner lowest priority.
        if (release_now) begin
          gnt_d    = '0;
          bus_en_d = 1'b0;
          ptr_d    = sel_q + 2'd1;
        end
      end
      default: begin
        gnt_d      = '0;
        sel_d      = '0;
        bus_en_d   = 1'b0;
        ptr_d      = '0;
        hold_cnt_d = '0;
        y_d        = '0;
        y_valid_d  = 1'b0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign bus_en  = bus_en_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Scoreboard bench for bus_arbiter_rr4: directed steps push expected cycle
// records and bus samples; a negedge monitor pops and compares them.
module tb_bus_arbiter_rr4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_en;
  logic [7:0] y;
  logic       y_valid;

  bus_arbiter_rr4 #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .bus_en(bus_en), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_en;
    logic       y_valid;
    logic [7:0] y;
  } exp_t;

  exp_t       ctrl_q[$];
  logic [7:0] data_q[$];
  logic [7:0] dv [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [1:0] cur_sel;
  logic       prev_en;
  logic [7:0] exp_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [1:0] idx(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Drive req for the coming edge and record what the DUT must show after it.
  task automatic step(input logic [3:0] r, input logic [3:0] g);
    exp_t e;
    req       = r;
    e.tag     = cyc + 1;
    e.y       = prev_en ? dv[cur_sel] : exp_y;
    e.y_valid = prev_en;
    if (g != 4'b0000) cur_sel = idx(g);
    e.gnt    = g;
    e.sel    = cur_sel;
    e.bus_en = (g != 4'b0000);
    if (e.bus_en) data_q.push_back(dv[cur_sel]);
    exp_y   = e.y;
    prev_en = e.bus_en;
    ctrl_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #5;
    rst = 1'b1;
    #1;
    check("rst_mid_gnt", gnt, 4'b0000);
    check("rst_mid_bus_en", bus_en, 1'b0);
    check("rst_mid_y_valid", y_valid, 1'b0);
    check("rst_mid_y", y, 8'h00);
    rst = 1'b0;
    // The sample for the interrupted owning cycle is lost with the reset.
    if (data_q.size() > 0) data_q.delete(data_q.size() - 1);
    cur_sel = 2'd0;
    prev_en = 1'b0;
    exp_y   = 8'h00;
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("gnt_onehot", ($countones(gnt) <= 1), 1'b1);
    check("gnt_vs_bus_en", (gnt != 4'b0000), bus_en);
    while (ctrl_q.size() > 0 && ctrl_q[0].tag <= cyc) begin
      e = ctrl_q.pop_front();
      check("gnt", gnt, e.gnt);
      check("sel", sel, e.sel);
      check("bus_en", bus_en, e.bus_en);
      check("y_valid", y_valid, e.y_valid);
      check("y", y, e.y);
    end
    if (y_valid) begin
      if (data_q.size() == 0) check("y_unexpected_sample", y_valid, 1'b0);
      else check("y_sample", y, data_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'hA5; dv[3] = 8'h3C;
    d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
    rst = 1'b1;
    req = 4'b1111;
    cur_sel = 2'd0;
    prev_en = 1'b0;
    exp_y   = 8'h00;

    // Reset held across edges with every requester active.
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_gnt", gnt, 4'b0000);
      check("rst_bus_en", bus_en, 1'b0);
      check("rst_y_valid", y_valid, 1'b0);
      check("rst_sel", sel, 2'd0);
      check("rst_y", y, 8'h00);
    end
    rst = 1'b0;

    // All four requesting: owners 0,1,2,3,0 with 4 cycles each and a dead cycle between.
    for (int o = 0; o < 4; o++) begin
      repeat (4) step(4'b1111, 4'b0001 << o);
      step(4'b1111, 4'b0000);
    end
    repeat (4) step(4'b1111, 4'b0001);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Lone requester 2 keeps the bus past the hold limit; d2 = A5 is sampled.
    repeat (10) step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Owner 1 drops; during TURN req 3 and a re-raised req 0 compete with ptr=2.
    step(4'b0010, 4'b0010);
    step(4'b0010, 4'b0010);
    step(4'b1000, 4'b0000);
    step(4'b1001, 4'b1000);
    step(4'b1001, 4'b1000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Move ptr to 2, then reset in the middle of owner 2's tenure.
    step(4'b0010, 4'b0010);
    step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0100);
    reset_pulse();
    repeat (4) step(4'b1111, 4'b0001);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    @(negedge clk);
    #1;
    check("ctrl_queue_drained", ctrl_q.size(), 0);
    check("data_queue_drained", data_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
